// File: rtl/p_div_pkg.sv
// rtl/p_div_pkg.sv - shared perceptron types plus divider state and sizing helper
// Purpose: operand format description (dtype_t, dconf_t), the p_div FSM
//          state enum and a function deriving the divider's SHIFT and ITER.
// Ports:   none (package).
package p_div_pkg;

  typedef enum logic {INT, FXP} dtype_t;
  typedef enum logic {Disable, Enable} sign_t;

  // prec: total bit width, frac: fractional bits (0 for INT).
  typedef struct packed {
    dtype_t     dtype;
    sign_t      sign;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;

  typedef enum logic [1:0] {IDLE, CALC, DONE} p_div_state_t;

  typedef struct packed {
    int shift;
    int iter;
  } div_dims_t;

  // shift: left alignment of the dividend so the quotient lands on O.frac
  // fractional bits. iter: number of quotient bits, one per cycle.
  function automatic div_dims_t p_div_dims(dconf_t i1, dconf_t i2, dconf_t o);
    div_dims_t d;
    d.shift = int'(o.frac) - int'(i1.frac) + int'(i2.frac);
    d.iter  = int'(i1.prec) + d.shift;
    return d;
  endfunction

endpackage

// File: rtl/p_div_norm.sv
// rtl/p_div_norm.sv - sign application, saturation and flags for a divider quotient
// Purpose: turns an unsigned magnitude quotient into the output format.
// Ports:
//   q        in  ITER : magnitude quotient
//   r_nz     in  1    : remainder was nonzero
//   neg      in  1    : result is negative
//   dz       in  1    : divisor was zero
//   in1_neg  in  1    : dividend was negative (selects dz saturation side)
//   out      out PO   : formatted quotient
//   udf/ovf/rounded out 1 : result flags
module p_div_norm #(
  parameter int ITER  = 14,
  parameter int PO    = 8,
  parameter bit OSIGN = 1'b1
) (
  input  logic [ITER-1:0] q,
  input  logic            r_nz,
  input  logic            neg,
  input  logic            dz,
  input  logic            in1_neg,
  output logic [PO-1:0]   out,
  output logic            udf,
  output logic            ovf,
  output logic            rounded
);

  // One spare bit so the limits and the quotient compare without wrap.
  localparam int W = ((ITER > PO) ? ITER : PO) + 1;
  localparam logic [W-1:0]  ONE     = W'(1);
  localparam logic [W-1:0]  POS_LIM = (ONE << (PO - int'(OSIGN))) - ONE;
  localparam logic [W-1:0]  NEG_LIM = ONE << (PO - 1);
  localparam logic [PO-1:0] MAX_OUT = POS_LIM[PO-1:0];
  localparam logic [PO-1:0] MIN_OUT = NEG_LIM[PO-1:0];

  logic [W-1:0]  q_ext;
  logic [PO-1:0] q_lo;

  assign q_ext = W'(q);
  assign q_lo  = q_ext[PO-1:0];

  always_comb begin
    out     = '0;
    udf     = 1'b0;
    ovf     = 1'b0;
    rounded = 1'b0;
    if (dz) begin
      ovf = 1'b1;
      out = in1_neg ? MIN_OUT : MAX_OUT;
    end else begin
      rounded = r_nz;
      udf     = (q == '0) && r_nz;
      if (q_ext > (neg ? NEG_LIM : POS_LIM)) begin
        ovf = 1'b1;
        out = neg ? MIN_OUT : MAX_OUT;
      end else begin
        // Negating the limit magnitude 2^(PO-1) yields exactly MIN_OUT.
        out = neg ? -q_lo : q_lo;
      end
    end
  end

endmodule

// File: rtl/p_div.sv
// rtl/p_div.sv - iterative restoring divider, one quotient bit per cycle
// Purpose: out = in1 / in2 for dconf_t-described operands, truncating toward 0.
// Ports:
//   clk, reset_ (async, active-low)
//   in_valid/in_ready       : operand handshake, in1 (I1.prec), in2 (I2.prec)
//   out_valid/out_ready     : result handshake, out (O.prec)
//   udf, ovf, rounded, dz   : result flags, held with out
module p_div
  import p_div_pkg::*;
#(
  parameter dconf_t I1_CONF = '{INT, Enable, 8'd8, 8'd0},
  parameter dconf_t I2_CONF = '{INT, Enable, 8'd8, 8'd0},
  parameter dconf_t O_CONF  = '{INT, Enable, 8'd8, 8'd0}
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [int'(I1_CONF.prec)-1:0] in1,
  input  logic [int'(I2_CONF.prec)-1:0] in2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [int'(O_CONF.prec)-1:0]  out,
  output logic                          udf,
  output logic                          ovf,
  output logic                          rounded,
  output logic                          dz
);

  localparam int        P1    = int'(I1_CONF.prec);
  localparam int        P2    = int'(I2_CONF.prec);
  localparam int        PO    = int'(O_CONF.prec);
  localparam div_dims_t DIMS  = p_div_dims(I1_CONF, I2_CONF, O_CONF);
  localparam int        SHIFT = DIMS.shift;
  localparam int        ITER  = DIMS.iter;
  localparam int        CW    = $clog2(ITER + 1);
  localparam bit        S1    = (I1_CONF.sign == Enable);
  localparam bit        S2    = (I2_CONF.sign == Enable);
  localparam bit        OS    = (O_CONF.sign == Enable);

  if (SHIFT < 0) begin : g_chk_shift
    $error("p_div: O.frac - I1.frac + I2.frac must not be negative");
  end
  if (OS != (S1 || S2)) begin : g_chk_sign
    $error("p_div: O.sign must equal I1.sign || I2.sign");
  end

  p_div_state_t state, state_nxt;
  logic         accept, last;

  // num starts as the aligned dividend; quotient bits shift in from the LSB
  // as dividend bits leave at the MSB, so after ITER steps it holds q.
  logic [ITER-1:0] num, q_nxt;
  logic [P2-1:0]   rem, rem_nxt, dvs;
  logic [CW-1:0]   cnt;
  logic            neg, in1_neg, dz_r;

  logic            s1, s2, fits;
  logic [P1-1:0]   mag1;
  logic [P2-1:0]   mag2;
  logic [P2:0]     trial, diff;

  logic [PO-1:0]   n_out;
  logic            n_udf, n_ovf, n_rounded;

  assign s1   = S1 && in1[P1-1];
  assign s2   = S2 && in2[P2-1];
  assign mag1 = s1 ? -in1 : in1;
  assign mag2 = s2 ? -in2 : in2;

  // trial < 2*dvs always, so the borrow out of diff decides the subtract.
  assign trial   = {rem, num[ITER-1]};
  assign diff    = trial - {1'b0, dvs};
  assign fits    = ~diff[P2];
  assign rem_nxt = fits ? diff[P2-1:0] : trial[P2-1:0];
  assign q_nxt   = {num[ITER-2:0], fits};

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == CW'(1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  p_div_norm #(
    .ITER  (ITER),
    .PO    (PO),
    .OSIGN (OS)
  ) u_norm (
    .q       (q_nxt),
    .r_nz    (rem_nxt != '0),
    .neg     (neg),
    .dz      (dz_r),
    .in1_neg (in1_neg),
    .out     (n_out),
    .udf     (n_udf),
    .ovf     (n_ovf),
    .rounded (n_rounded)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      num     <= '0;
      rem     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      in1_neg <= 1'b0;
      dz_r    <= 1'b0;
      out     <= '0;
      udf     <= 1'b0;
      ovf     <= 1'b0;
      rounded <= 1'b0;
      dz      <= 1'b0;
    end else begin
      if (accept) begin
        num     <= ITER'(mag1) << SHIFT;
        rem     <= '0;
        dvs     <= mag2;
        neg     <= s1 ^ s2;
        in1_neg <= s1;
        dz_r    <= (in2 == '0);
        // A zero divisor spends a single CALC cycle so its result is
        // registered through the same path as a normal quotient.
        cnt     <= (in2 == '0) ? CW'(1) : CW'(ITER);
      end else if (state == CALC) begin
        num <= q_nxt;
        rem <= rem_nxt;
        cnt <= cnt - CW'(1);
      end
      if (last) begin
        out     <= n_out;
        udf     <= n_udf;
        ovf     <= n_ovf;
        rounded <= n_rounded;
        dz      <= dz_r;
      end
    end
  end

endmodule

// File: tb/tb_p_div.sv
// tb/tb_p_div.sv - scoreboard testbench for p_div (configs A and B)
module tb_p_div;
  import p_div_pkg::*;

  localparam dconf_t CI   = '{FXP, Enable, 8'd8, 8'd3};
  localparam dconf_t CO_A = '{FXP, Enable, 8'd16, 8'd6};
  localparam dconf_t CO_B = '{FXP, Enable, 8'd8, 8'd3};

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        va = 1'b0, rdy_a = 1'b1;
  logic [7:0]  a1 = '0, a2 = '0;
  logic        ira, ova, ua, ovfa, ra, dza;
  logic [15:0] oa;

  logic        vb = 1'b0, rdy_b = 1'b1;
  logic [7:0]  b1 = '0, b2 = '0;
  logic        irb, ovb, ub, ovfb, rb, dzb;
  logic [7:0]  ob;

  p_div #(.I1_CONF(CI), .I2_CONF(CI), .O_CONF(CO_A)) u_a (
    .clk(clk), .reset_(reset_), .in_valid(va), .in_ready(ira),
    .in1(a1), .in2(a2), .out_valid(ova), .out_ready(rdy_a),
    .out(oa), .udf(ua), .ovf(ovfa), .rounded(ra), .dz(dza)
  );

  p_div #(.I1_CONF(CI), .I2_CONF(CI), .O_CONF(CO_B)) u_b (
    .clk(clk), .reset_(reset_), .in_valid(vb), .in_ready(irb),
    .in1(b1), .in2(b2), .out_valid(ovb), .out_ready(rdy_b),
    .out(ob), .udf(ub), .ovf(ovfb), .rounded(rb), .dz(dzb)
  );

  // flags packed as {udf, ovf, rounded, dz}
  typedef struct {
    logic [15:0] out;
    logic [3:0]  flags;
    int          lat;
    int          stamp;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  logic [19:0] res_a, res_b, held_a, held_b;
  logic        prev_a = 1'b0, prev_b = 1'b0;
  exp_t        cur_a, cur_b;

  assign res_a = {oa, ua, ovfa, ra, dza};
  assign res_b = {8'h00, ob, ub, ovfb, rb, dzb};

  always @(negedge clk) begin
    if (!reset_) begin
      prev_a = 1'b0;
      prev_b = 1'b0;
    end else begin
      if (ova && !prev_a) begin
        check("a_expected_present", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
          cur_a = q_a.pop_front();
          check("a_result", 32'(res_a), 32'({cur_a.out, cur_a.flags}));
          check("a_latency", cyc - cur_a.stamp, cur_a.lat);
        end
        held_a = res_a;
      end else if (ova) begin
        check("a_hold", 32'(res_a), 32'(held_a));
      end
      if (ovb && !prev_b) begin
        check("b_expected_present", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) begin
          cur_b = q_b.pop_front();
          check("b_result", 32'(res_b), 32'({cur_b.out, cur_b.flags}));
          check("b_latency", cyc - cur_b.stamp, cur_b.lat);
        end
        held_b = res_b;
      end else if (ovb) begin
        check("b_hold", 32'(res_b), 32'(held_b));
      end
      prev_a = ova;
      prev_b = ovb;
    end
  end

  task automatic issue(input bit use_b, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] eo, input logic [3:0] ef, input int lat,
                       input bit expect_result);
    int t = 0;
    @(negedge clk);
    while (!(use_b ? irb : ira) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(use_b ? "b_accept_ready" : "a_accept_ready", 32'(use_b ? irb : ira), 32'd1);
    if (use_b) begin b1 = x; b2 = y; vb = 1'b1; end
    else       begin a1 = x; a2 = y; va = 1'b1; end
    if (expect_result) begin
      if (use_b) q_b.push_back('{eo, ef, lat, cyc + 1});
      else       q_a.push_back('{eo, ef, lat, cyc + 1});
    end
    @(negedge clk);
    va = 1'b0;
    vb = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || !ira || !irb) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", 32'(q_a.size() + q_b.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a"}, {ira, ova, oa, ua, ovfa, ra, dza}, {2'b10, 16'h0000, 4'b0000});
    check({tag, "_b"}, {irb, ovb, ob, ub, ovfb, rb, dzb}, {2'b10, 8'h00, 4'b0000});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset_state");
    reset_ = 1'b1;

    // Config A: SHIFT 6, ITER 14
    issue(1'b0, 8'h1C, 8'h10, 16'h0070, 4'b0000, 14, 1'b1);
    drain();
    issue(1'b0, 8'hE4, 8'h10, 16'hFF90, 4'b0000, 14, 1'b1);
    drain();
    issue(1'b0, 8'h08, 8'h18, 16'h0015, 4'b0010, 14, 1'b1);
    drain();
    issue(1'b0, 8'h00, 8'h18, 16'h0000, 4'b0000, 14, 1'b1);
    drain();

    // Config B: SHIFT 3, ITER 11
    issue(1'b1, 8'h78, 8'h01, 16'h007F, 4'b0100, 11, 1'b1);
    drain();
    issue(1'b1, 8'h01, 8'h7F, 16'h0000, 4'b1010, 11, 1'b1);
    drain();
    issue(1'b1, 8'h80, 8'h08, 16'h0080, 4'b0000, 11, 1'b1);
    drain();

    // Divide by zero, negative dividend saturates to min
    issue(1'b0, 8'hE4, 8'h00, 16'h8000, 4'b0101, 1, 1'b1);
    drain();

    // Divide by zero with backpressure; new operands must be ignored
    rdy_a = 1'b0;
    issue(1'b0, 8'h28, 8'h00, 16'h7FFF, 4'b0101, 1, 1'b1);
    begin
      int t = 0;
      while (!ova && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    check("dz_valid_seen", 32'(ova), 32'd1);
    for (int i = 0; i < 5; i++) begin
      a1 = 8'h10; a2 = 8'h08; va = 1'b1;
      @(negedge clk);
      check("dz_backpressure_in_ready", 32'(ira), 32'd0);
      check("dz_backpressure_valid", 32'(ova), 32'd1);
    end
    va = 1'b0;
    rdy_a = 1'b1;
    drain();

    // Reset mid-CALC: no result may be emitted
    issue(1'b0, 8'h1C, 8'h10, 16'h0000, 4'b0000, 14, 1'b0);
    repeat (3) @(negedge clk);
    check("calc_busy", {ira, ova}, 2'b00);
    #2 reset_ = 1'b0;
    #1 check_reset_vals("async_reset");
    repeat (2) @(negedge clk);
    reset_ = 1'b1;

    // Recovery after the aborted operation
    issue(1'b0, 8'h1C, 8'h10, 16'h0070, 4'b0000, 14, 1'b1);
    drain();
    repeat (20) @(negedge clk);
    check("no_leftover_a", 32'(q_a.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
